pipe_sub_cla: RTL and testbench
===============================

PIPE_SUB_CLA -- requirements
Module: pipe_sub_cla

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits.
REQ-002 Parameter: GROUP, 4, bits resolved per cycle by one carry-lookahead group; WIDTH SHALL be an integer multiple of GROUP; N = WIDTH/GROUP.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin a subtraction; sampled on rising edge.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 ready  output  1  block idle and able to accept start.
REQ-009 done  output  1  one-cycle pulse: result outputs valid.
REQ-010 diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-011 borrow  output  1  1 when unsigned a < b.
REQ-012 ovf  output  1  signed two's-complement overflow of a - b.
REQ-013 zero  output  1  1 when diff == 0.

Function
REQ-014 Arithmetic SHALL be a + ~b + 1; group k bit i: p = a_i ^ ~b_i, g = a_i & ~b_i; carry into bit i+1 = g | (p & carry_i); sum = p ^ carry_i.
REQ-015 Carry into group 0 SHALL be 1; carry between groups SHALL be held in a 1-bit register.
REQ-016 Within a group, carries SHALL be lookahead (flattened p/g terms), not rippled through registers.
REQ-017 States: IDLE, RUN, DONE; ready = 1 only in IDLE.
REQ-018 IDLE with start = 1 at edge E0: latch a, b; group counter = 0; carry register = 1; go to RUN.
REQ-019 IDLE with start = 0: remain IDLE; outputs hold previous values.
REQ-020 RUN: each edge SHALL compute group counter's GROUP bits into diff, update carry register, increment counter.
REQ-021 RUN with counter == N-1: after computing last group go to DONE; done registered high.
REQ-022 done SHALL be high for exactly the cycle following edge E0+N (N edges after acceptance), i.e. while in DONE.
REQ-023 In DONE cycle: borrow = ~final carry; ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]); zero = (diff == 0); all using latched operands.
REQ-024 DONE SHALL go to IDLE on next edge unconditionally; start in DONE SHALL be ignored.
REQ-025 start while in RUN or DONE SHALL be ignored; latched operands SHALL NOT change.
REQ-026 Changes on a, b after E0 SHALL NOT affect the result.
REQ-027 diff, borrow, ovf, zero SHALL hold stable from DONE until the next accepted start; during RUN, diff upper groups MAY show partial values and borrow/ovf/zero SHALL hold previous result.
REQ-028 Back-to-back start (asserted continuously) SHALL yield one operation per N+2 cycles.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force state IDLE, counter 0, carry register 1, diff 0, borrow 0, ovf 0, zero 0, done 0, ready 1.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; first start after rst_n rises SHALL be accepted normally.

Verification
REQ-031 a=0x0005, b=0x0003, start 1 cycle -> done 4 edges after acceptance; diff=0x0002, borrow=0, ovf=0, zero=0.
REQ-032 a=0x0003, b=0x0005 -> diff=0xFFFE, borrow=1, ovf=0, zero=0; a=0x0100, b=0x0001 -> diff=0x00FF (carry across 3 groups).
REQ-033 a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1; a=0x1234, b=0x1234 -> diff=0x0000, zero=1, borrow=0.
REQ-034 start pulsed with new operands during RUN and in DONE -> ignored; result matches first operands; ready=0 throughout RUN/DONE.
REQ-035 rst_n pulsed low during 2nd RUN cycle -> outputs/state at reset values immediately, no done; next start with 0x0005/0x0003 -> diff=0x0002.
REQ-036 Random sweep of 1000 operand pairs, start held high -> each done matches golden a-b, borrow, ovf, zero; done spacing exactly N+2 cycles.

Source files
------------

// File: rtl/pipe_sub_cla.sv
// ============================================================================
// Module      : pipe_sub_cla
// Description : Multi-cycle subtractor; one GROUP-bit carry-lookahead slice
//               per clock, chained through a 1-bit carry register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_sub_cla #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = WIDTH / GROUP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int MSB   = WIDTH - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [GROUP-1:0] grp_a, grp_b, grp_p, grp_g, grp_sum;
    logic [GROUP:0]   grp_c;
    logic             last_grp;

    // Carry into bit i+1 as a single sum-of-products over the group's p/g terms.
    function automatic logic lookahead(input logic [GROUP-1:0] p, input logic [GROUP-1:0] g,
                                       input logic cin, input int i);
        logic acc, prod;
        acc = 1'b0;
        for (int j = 0; j <= i; j++) begin
            prod = g[j];
            for (int m = j + 1; m <= i; m++) prod = prod & p[m];
            acc = acc | prod;
        end
        prod = cin;
        for (int m = 0; m <= i; m++) prod = prod & p[m];
        return acc | prod;
    endfunction

    always_comb begin
        grp_a = '0;
        grp_b = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                grp_a = a_q[k*GROUP +: GROUP];
                grp_b = b_q[k*GROUP +: GROUP];
            end
        end
    end

    // Subtraction as a + ~b + 1: the +1 enters as the initial carry.
    always_comb begin
        grp_p    = grp_a ^ ~grp_b;
        grp_g    = grp_a & ~grp_b;
        grp_c    = '0;
        grp_c[0] = carry_q;
        for (int i = 0; i < GROUP; i++) begin
            grp_c[i+1] = lookahead(grp_p, grp_g, carry_q, i);
        end
        grp_sum  = grp_p ^ grp_c[GROUP-1:0];
        last_grp = (cnt_q == CNT_W'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_grp) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == S_IDLE);
        done  = (state_q == S_DONE);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                end
            end
            S_RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CNT_W'(k)) diff_d[k*GROUP +: GROUP] = grp_sum;
                end
                carry_d = grp_c[GROUP];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_grp) begin
                    cnt_d    = '0;
                    borrow_d = ~grp_c[GROUP];
                    ovf_d    = (a_q[MSB] ^ b_q[MSB]) & (diff_d[MSB] ^ a_q[MSB]);
                    zero_d   = (diff_d == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b1;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_sub_cla.sv
// ============================================================================
// Module      : tb_pipe_sub_cla
// Description : Directed and randomized bench for pipe_sub_cla.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_sub_cla;

    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int N     = WIDTH / GROUP;
    localparam int NOPS  = 1000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             ready, done, borrow, ovf, zero;
    logic [WIDTH-1:0] diff;

    int checks   = 0;
    int failures = 0;

    logic             prev_borrow, prev_ovf, prev_zero;
    logic [WIDTH-1:0] prev_diff;

    always #5 clk = ~clk;

    pipe_sub_cla #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf),
        .zero   (zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result {borrow, ovf, zero, diff} from plain integer arithmetic.
    function automatic logic [WIDTH+2:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int               ux, uy, sx, sy, sd;
        logic [WIDTH-1:0] dv;
        logic             bo, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        sd = sx - sy;
        dv = WIDTH'(ux - uy);
        bo = (ux < uy);
        ov = (sd > (2 ** (WIDTH - 1)) - 1) || (sd < -(2 ** (WIDTH - 1)));
        return {bo, ov, (dv == '0), dv};
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input bit disturb, input string tag);
        logic [WIDTH+2:0] r;
        int               lat;
        r   = ref_sub(x, y);
        lat = 0;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!done) begin
                chk({tag, "_ready_run"}, 32'(ready), 32'd0);
                chk({tag, "_flags_hold"}, {29'd0, borrow, ovf, zero},
                    {29'd0, prev_borrow, prev_ovf, prev_zero});
                start = disturb;
                if (disturb) begin
                    a = WIDTH'($urandom);
                    b = WIDTH'($urandom);
                end
            end
        end while (!done && lat < 4 * N);
        chk({tag, "_latency"}, 32'(lat), 32'(N + 1));
        chk({tag, "_diff"}, 32'(diff), 32'(r[WIDTH-1:0]));
        chk({tag, "_borrow"}, 32'(borrow), 32'(r[WIDTH+2]));
        chk({tag, "_ovf"}, 32'(ovf), 32'(r[WIDTH+1]));
        chk({tag, "_zero"}, 32'(zero), 32'(r[WIDTH]));
        chk({tag, "_ready_done"}, 32'(ready), 32'd0);
        start = disturb;
        if (disturb) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_ready_idle"}, 32'(ready), 32'd1);
        chk({tag, "_diff_hold"}, 32'(diff), 32'(r[WIDTH-1:0]));
        prev_diff   = r[WIDTH-1:0];
        prev_borrow = r[WIDTH+2];
        prev_ovf    = r[WIDTH+1];
        prev_zero   = r[WIDTH];
    endtask

    initial begin
        logic [WIDTH-1:0] qa[$], qb[$];
        logic [WIDTH-1:0] x, y;
        logic [WIDTH+2:0] r;
        int               since, got;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_outs", {15'd0, diff, borrow, ovf, zero}, 32'd0);
        rst_n = 1'b1;

        run_op(16'h0005, 16'h0003, 1'b0, "d5m3");
        run_op(16'h0003, 16'h0005, 1'b0, "d3m5");
        run_op(16'h0100, 16'h0001, 1'b0, "d100m1");
        run_op(16'h8000, 16'h0001, 1'b0, "d8000m1");
        run_op(16'h1234, 16'h1234, 1'b0, "dsame");

        repeat (3) @(negedge clk);
        chk("idle_hold", {15'd0, diff, borrow, ovf, zero},
            {15'd0, prev_diff, prev_borrow, prev_ovf, prev_zero});

        run_op(16'h7FFF, 16'hFFFF, 1'b1, "ignore_start");
        run_op(16'h8000, 16'h0001, 1'b0, "pre_rst");

        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_ready", 32'(ready), 32'd1);
        chk("midrun_rst_done", 32'(done), 32'd0);
        chk("midrun_rst_outs", {15'd0, diff, borrow, ovf, zero}, 32'd0);
        repeat (N + 3) begin
            @(negedge clk);
            chk("midrun_rst_nodone", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
        run_op(16'h0005, 16'h0003, 1'b0, "post_rst");

        @(negedge clk);
        x = WIDTH'($urandom);
        y = WIDTH'($urandom);
        qa.push_back(x); qb.push_back(y);
        a = x; b = y; start = 1'b1;
        since = 0;
        got   = 0;
        while (got < NOPS) begin
            @(negedge clk);
            since++;
            if (since > 3 * (N + 2)) begin
                chk("sweep_timeout", 32'(since), 32'(N + 2));
                break;
            end
            if (done) begin
                chk("sweep_spacing", 32'(since), (got == 0) ? 32'(N + 1) : 32'(N + 2));
                x = qa.pop_front();
                y = qb.pop_front();
                r = ref_sub(x, y);
                chk("sweep_diff", 32'(diff), 32'(r[WIDTH-1:0]));
                chk("sweep_borrow", 32'(borrow), 32'(r[WIDTH+2]));
                chk("sweep_ovf", 32'(ovf), 32'(r[WIDTH+1]));
                chk("sweep_zero", 32'(zero), 32'(r[WIDTH]));
                got++;
                since = 0;
                if (got < NOPS) begin
                    x = WIDTH'($urandom);
                    y = ($urandom_range(0, 15) == 0) ? x : WIDTH'($urandom);
                    if ($urandom_range(0, 15) == 0) x = 16'h8000;
                    qa.push_back(x); qb.push_back(y);
                    a = x; b = y;
                end else begin
                    start = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
